// File: rtl/p2_mailbox_ctrl_if.sv
// Byte-stream and P2 port-register signals between the mailbox controller and its neighbours.
// The controller uses the slave view; the UART/register side uses the master view.
interface p2_mailbox_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_hold;
    logic       rx_ovf;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [3:0] p7_q;
    logic [3:0] p4_q;
    logic [3:0] p5_q;
    logic [3:0] p4_d;
    logic [3:0] p5_d;
    logic [3:0] p6_d;

    modport slave (
        input  rx_valid, rx_data, tx_ready, p7_q, p4_q, p5_q,
        output rx_hold, rx_ovf, tx_valid, tx_data, p4_d, p5_d, p6_d
    );

    modport master (
        output rx_valid, rx_data, tx_ready, p7_q, p4_q, p5_q,
        input  rx_hold, rx_ovf, tx_valid, tx_data, p4_d, p5_d, p6_d
    );
endinterface

// File: rtl/p2_mailbox_ctrl.sv
// Moves bytes between the UART streams and P2 ports 4-7: buffers received bytes in a FIFO,
// offers them to the MCU as nibbles, and forwards MCU-written bytes to UART TX.
module p2_mailbox_ctrl #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_MARGIN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    p2_mailbox_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] HOLD_LVL = LW'(DEPTH - HOLD_MARGIN);

    localparam logic [2:0] R_IDLE    = 3'd0;
    localparam logic [2:0] R_OFFER   = 3'd1;
    localparam logic [2:0] R_RELEASE = 3'd2;
    localparam logic [2:0] W_IDLE    = 3'd3;
    localparam logic [2:0] W_PUSH    = 3'd4;
    localparam logic [2:0] W_RELEASE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          mode_q;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          rx_hold_q, rx_ovf_q;
    logic          tx_valid_q;
    logic [7:0]    tx_data_q;
    logic [3:0]    nib_lo_q, nib_hi_q;
    logic          avail_n_q, avail_n_d;
    logic          empty_q, busy_q;
    logic          ack_n_q, ack_n_d;

    logic       full, push, pop, load, capture, tx_fire, mode_edge;
    logic [7:0] head;

    assign full      = (level_q == FULL_LVL);
    assign push      = bus.rx_valid && !full;
    assign tx_fire   = tx_valid_q && bus.tx_ready;
    assign mode_edge = (bus.p7_q[0] != mode_q);
    assign head      = mem[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        avail_n_d = avail_n_q;
        ack_n_d   = ack_n_q;
        pop       = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        // A mode flip abandons whichever handshake is running; the FIFO head is not consumed.
        if (mode_edge) begin
            state_d   = bus.p7_q[0] ? W_IDLE : R_IDLE;
            avail_n_d = 1'b1;
            ack_n_d   = 1'b1;
        end else begin
            unique case (state_q)
                R_IDLE: begin
                    if ((level_q != '0) && bus.p7_q[1]) begin
                        load    = 1'b1;
                        state_d = R_OFFER;
                    end
                end
                R_OFFER: begin
                    if (!bus.p7_q[1]) begin
                        pop       = 1'b1;
                        avail_n_d = 1'b1;
                        state_d   = R_RELEASE;
                    end else begin
                        avail_n_d = 1'b0;
                    end
                end
                R_RELEASE: if (bus.p7_q[1]) state_d = R_IDLE;
                W_IDLE: begin
                    // A byte still pending from before a mode flip must drain first.
                    if (!bus.p7_q[2] && !tx_valid_q) begin
                        capture = 1'b1;
                        state_d = W_PUSH;
                    end
                end
                W_PUSH: begin
                    if (tx_fire) begin
                        ack_n_d = 1'b0;
                        state_d = W_RELEASE;
                    end
                end
                W_RELEASE: begin
                    if (bus.p7_q[2]) begin
                        ack_n_d = 1'b1;
                        state_d = W_IDLE;
                    end
                end
                default: state_d = R_IDLE;
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= R_IDLE;
            mode_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_hold_q  <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            nib_lo_q   <= '0;
            nib_hi_q   <= '0;
            avail_n_q  <= 1'b1;
            empty_q    <= 1'b1;
            busy_q     <= 1'b1;
            ack_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= bus.p7_q[0];
            level_q   <= level_d;
            rx_hold_q <= (level_q >= HOLD_LVL);
            empty_q   <= (level_q == '0);
            busy_q    <= tx_valid_q;
            avail_n_q <= avail_n_d;
            ack_n_q   <= ack_n_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (bus.rx_valid && full) rx_ovf_q <= 1'b1;
            if (capture) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= {bus.p5_q, bus.p4_q};
            end else if (tx_fire) begin
                tx_valid_q <= 1'b0;
            end
            if (load) begin
                nib_lo_q <= head[3:0];
                nib_hi_q <= head[7:4];
            end
        end
    end

    assign bus.rx_hold  = rx_hold_q;
    assign bus.rx_ovf   = rx_ovf_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.p4_d     = nib_lo_q;
    assign bus.p5_d     = nib_hi_q;
    assign bus.p6_d     = {ack_n_q, busy_q, empty_q, avail_n_q};
endmodule
